// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: grants the bus to refresh, write or read stages with fixed priority.
// The optional grant watchdog is built only when ARBIT_WDT_EN is defined.
module sdram_arbit (
    input  logic        S_CLK,
    input  logic        RST,
    input  logic        flag_init,
    input  logic [4:0]  init_cmd,
    input  logic [11:0] init_addr,
    input  logic        aref_req,
    output logic        aref_en,
    input  logic        aref_ack,
    input  logic [4:0]  aref_cmd,
    input  logic [11:0] aref_addr,
    input  logic        wr_req,
    output logic        wr_en,
    input  logic        wr_ack,
    output logic        wr_break,
    input  logic [4:0]  wr_cmd,
    input  logic [11:0] wr_addr,
    input  logic        rd_req,
    output logic        rd_en,
    input  logic        rd_ack,
    output logic        rd_break,
    input  logic [4:0]  rd_cmd,
    input  logic [11:0] rd_addr,
    output logic [4:0]  sdram_cmd,
    output logic [11:0] sdram_addr,
    output logic        arb_err
);

    localparam logic [4:0] CmdNop = 5'b10111;

    typedef enum logic [2:0] {
        StIdle,
        StArbit,
        StAref,
        StWrite,
        StRead
    } state_e;

    state_e      state_q, state_d;
    logic        expire;
    logic        wdt_full;
    logic [4:0]  cmd_d;
    logic [11:0] addr_d;

    assign aref_en  = (state_q == StAref);
    assign wr_en    = (state_q == StWrite);
    assign rd_en    = (state_q == StRead);
    assign wr_break = aref_req & wr_en;
    assign rd_break = aref_req & rd_en;

`ifdef ARBIT_WDT_EN
    logic [7:0] wdt_q, wdt_d;
    logic       arb_err_q;

    // Counter sits at zero outside grant states, so every grant starts from zero.
    always_comb begin
        wdt_d = 8'd0;
        if (aref_en || wr_en || rd_en) begin
            wdt_d = wdt_q + 8'd1;
        end
    end

    always_ff @(posedge S_CLK) begin
        if (RST) begin
            wdt_q     <= 8'd0;
            arb_err_q <= 1'b0;
        end else begin
            wdt_q     <= wdt_d;
            arb_err_q <= expire;
        end
    end

    assign wdt_full = (wdt_q == 8'hff);
    assign arb_err  = arb_err_q;
`else
    assign wdt_full = 1'b0;
    assign arb_err  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        expire  = 1'b0;
        case (state_q)
            StIdle: begin
                if (flag_init) begin
                    state_d = StArbit;
                end
            end
            StArbit: begin
                if (aref_req) begin
                    state_d = StAref;
                end else if (wr_req) begin
                    state_d = StWrite;
                end else if (rd_req) begin
                    state_d = StRead;
                end
            end
            StAref: begin
                if (aref_ack) begin
                    state_d = StArbit;
                end else if (wdt_full) begin
                    state_d = StArbit;
                    expire  = 1'b1;
                end
            end
            StWrite: begin
                if (wr_ack) begin
                    state_d = StArbit;
                end else if (wdt_full) begin
                    state_d = StArbit;
                    expire  = 1'b1;
                end
            end
            StRead: begin
                if (rd_ack) begin
                    state_d = StArbit;
                end else if (wdt_full) begin
                    state_d = StArbit;
                    expire  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pins follow the stage owning the bus in the current cycle, one cycle later.
    always_comb begin
        cmd_d  = CmdNop;
        addr_d = 12'd0;
        case (state_q)
            StIdle: begin
                cmd_d  = init_cmd;
                addr_d = init_addr;
            end
            StAref: begin
                cmd_d  = aref_cmd;
                addr_d = aref_addr;
            end
            StWrite: begin
                cmd_d  = wr_cmd;
                addr_d = wr_addr;
            end
            StRead: begin
                cmd_d  = rd_cmd;
                addr_d = rd_addr;
            end
            default: begin
                cmd_d  = CmdNop;
                addr_d = 12'd0;
            end
        endcase
    end

    always_ff @(posedge S_CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            sdram_cmd  <= CmdNop;
            sdram_addr <= 12'd0;
        end else begin
            state_q    <= state_d;
            sdram_cmd  <= cmd_d;
            sdram_addr <= addr_d;
        end
    end

endmodule

// File: tb/tb_sdram_arbit.sv
// Scoreboard bench for sdram_arbit: a per-cycle reference model queues expected outputs,
// a monitor pops and compares them on the falling edge.
module tb_sdram_arbit;

    localparam logic [4:0] Nop = 5'b10111;
`ifdef ARBIT_WDT_EN
    localparam bit Wdt = 1'b1;
`else
    localparam bit Wdt = 1'b0;
`endif
    localparam int MIdle = 0, MArbit = 1, MAref = 2, MWrite = 3, MRead = 4;

    logic        S_CLK = 1'b0;
    logic        RST = 1'b1;
    logic        flag_init = 1'b0;
    logic [4:0]  init_cmd = '0, aref_cmd = '0, wr_cmd = '0, rd_cmd = '0;
    logic [11:0] init_addr = '0, aref_addr = '0, wr_addr = '0, rd_addr = '0;
    logic        aref_req = 1'b0, aref_ack = 1'b0, wr_req = 1'b0, wr_ack = 1'b0;
    logic        rd_req = 1'b0, rd_ack = 1'b0;
    logic        aref_en, wr_en, rd_en, wr_break, rd_break, arb_err;
    logic [4:0]  sdram_cmd;
    logic [11:0] sdram_addr;

    sdram_arbit dut (
        .S_CLK(S_CLK), .RST(RST), .flag_init(flag_init),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .aref_req(aref_req), .aref_en(aref_en), .aref_ack(aref_ack),
        .aref_cmd(aref_cmd), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_en(wr_en), .wr_ack(wr_ack), .wr_break(wr_break),
        .wr_cmd(wr_cmd), .wr_addr(wr_addr),
        .rd_req(rd_req), .rd_en(rd_en), .rd_ack(rd_ack), .rd_break(rd_break),
        .rd_cmd(rd_cmd), .rd_addr(rd_addr),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .arb_err(arb_err)
    );

    always #5 S_CLK = ~S_CLK;

    typedef struct packed {
        logic [2:0]  en;
        logic [1:0]  brk;
        logic [4:0]  cmd;
        logic [11:0] addr;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: which stage owns the bus, and what the pins will show next.
    int          m_owner = MIdle;
    int          m_age = 0;
    bit          m_valid = 1'b0;
    logic [4:0]  m_cmd = Nop;
    logic [11:0] m_addr = '0;
    logic        m_err = 1'b0;

    task automatic rand_buses();
        init_cmd  = 5'($urandom); init_addr = 12'($urandom);
        aref_cmd  = 5'($urandom); aref_addr = 12'($urandom);
        wr_cmd    = 5'($urandom); wr_addr   = 12'($urandom);
        rd_cmd    = 5'($urandom); rd_addr   = 12'($urandom);
    endtask

    task automatic clear_ctl();
        aref_req = 0; wr_req = 0; rd_req = 0;
        aref_ack = 0; wr_ack = 0; rd_ack = 0;
        flag_init = 0; RST = 0;
    endtask

    // Queue the expectation for the current cycle, advance the model, then cross one edge.
    task automatic cycle();
        exp_t e;
        int   nxt;
        logic done;
        logic timeout;
        if (m_valid) begin
            e.en   = {m_owner == MAref, m_owner == MWrite, m_owner == MRead};
            e.brk  = {aref_req && m_owner == MWrite, aref_req && m_owner == MRead};
            e.cmd  = m_cmd;
            e.addr = m_addr;
            e.err  = m_err;
            exp_q.push_back(e);
        end
        nxt = m_owner;
        timeout = 1'b0;
        done = (m_owner == MAref && aref_ack) || (m_owner == MWrite && wr_ack) ||
               (m_owner == MRead && rd_ack);
        if (m_owner == MIdle) begin
            if (flag_init) nxt = MArbit;
        end else if (m_owner == MArbit) begin
            if (aref_req) nxt = MAref;
            else if (wr_req) nxt = MWrite;
            else if (rd_req) nxt = MRead;
        end else if (done) begin
            nxt = MArbit;
        end else if (Wdt && m_age == 255) begin
            nxt = MArbit;
            timeout = 1'b1;
        end
        case (m_owner)
            MIdle:   begin m_cmd = init_cmd; m_addr = init_addr; end
            MAref:   begin m_cmd = aref_cmd; m_addr = aref_addr; end
            MWrite:  begin m_cmd = wr_cmd;   m_addr = wr_addr;   end
            MRead:   begin m_cmd = rd_cmd;   m_addr = rd_addr;   end
            default: begin m_cmd = Nop;      m_addr = '0;        end
        endcase
        m_age = (m_owner >= MAref) ? m_age + 1 : 0;
        if (RST) begin
            nxt = MIdle; m_cmd = Nop; m_addr = '0; timeout = 1'b0; m_age = 0; m_valid = 1'b1;
        end
        m_err = timeout;
        m_owner = nxt;
        @(posedge S_CLK);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            rand_buses();
            cycle();
        end
    endtask

    initial begin : monitor
        exp_t e;
        exp_t got;
        forever begin
            @(negedge S_CLK);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {aref_en, wr_en, rd_en, wr_break, rd_break, sdram_cmd, sdram_addr, arb_err};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got en=%b brk=%b cmd=%b addr=%h err=%b want en=%b brk=%b cmd=%b addr=%h err=%b",
                             $time, got.en, got.brk, got.cmd, got.addr, got.err,
                             e.en, e.brk, e.cmd, e.addr, e.err);
                end
            end
        end
    end

    initial begin : stimulus
        // Reset held three cycles, idle until flag_init, then ARBIT with NOP.
        clear_ctl();
        RST = 1;
        run(3);
        RST = 0;
        run(3);
        flag_init = 1;
        run(1);
        flag_init = 0;
        run(3);

        // All three requests together: refresh, then write, then read, ARBIT between.
        aref_req = 1; wr_req = 1; rd_req = 1;
        run(3);
        aref_ack = 1; aref_req = 0;
        run(1);
        aref_ack = 0;
        run(4);
        wr_ack = 1; wr_req = 0;
        run(1);
        wr_ack = 0;
        run(4);
        rd_ack = 1; rd_req = 0;
        run(1);
        rd_ack = 0;
        run(2);

        // Refresh request during a write raises wr_break; refresh follows the write.
        wr_req = 1;
        run(3);
        aref_req = 1;
        run(4);
        wr_ack = 1; wr_req = 0;
        run(1);
        wr_ack = 0;
        run(3);
        aref_ack = 1; aref_req = 0;
        run(1);
        aref_ack = 0;
        run(2);

        // Refresh command passes through with one cycle latency; stray rd_ack ignored.
        aref_req = 1;
        run(2);
        rand_buses();
        aref_cmd = 5'b10010;
        cycle();
        rd_ack = 1;
        run(2);
        rd_ack = 0;
        aref_ack = 1; aref_req = 0;
        run(1);
        aref_ack = 0;
        run(2);

        // Reset in the middle of a read, then IDLE until flag_init.
        rd_req = 1;
        run(4);
        RST = 1;
        run(1);
        RST = 0; rd_req = 0;
        run(4);
        flag_init = 1;
        run(1);
        flag_init = 0;
        run(2);

        // Write grant with no ack for 300 cycles: watchdog abort only when built in.
        wr_req = 1;
        run(2);
        wr_req = 0;
        run(300);
        wr_ack = 1;
        run(1);
        clear_ctl();
        run(3);

        // Randomized traffic, including stray acks and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            RST       = ($urandom_range(0, 99) == 0);
            flag_init = ($urandom_range(0, 3) == 0);
            aref_req  = ($urandom_range(0, 3) == 0);
            wr_req    = 1'($urandom);
            rd_req    = 1'($urandom);
            aref_ack  = ($urandom_range(0, 2) == 0);
            wr_ack    = ($urandom_range(0, 2) == 0);
            rd_ack    = ($urandom_range(0, 2) == 0);
            rand_buses();
            cycle();
        end

        @(negedge S_CLK);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 SHALL have ports (name, direction, width, meaning); clock and reset are listed first.
- S_CLK  in  1  system clock; all logic is on the rising edge
- RST  in  1  reset, synchronous, active-high
- flag_init  in  1  SDRAM power-up init complete; level signal
- init_cmd  in  5  init-stage command {CKE,CS_n,RAS_n,CAS_n,WE_n}
- init_addr  in  12  init-stage address
- aref_req  in  1  auto-refresh request
- aref_en  out  1  auto-refresh grant
- aref_ack  in  1  auto-refresh sequence done
- aref_cmd  in  5  refresh-stage command
- aref_addr  in  12  refresh-stage address
- wr_req  in  1  write burst request
- wr_en  out  1  write grant
- wr_ack  in  1  write burst done
- wr_break  out  1  refresh pending; writer must end its burst
- wr_cmd  in  5  write-stage command
- wr_addr  in  12  write-stage address
- rd_req  in  1  read burst request
- rd_en  out  1  read grant
- rd_ack  in  1  read burst done
- rd_break  out  1  refresh pending; reader must end its burst
- rd_cmd  in  5  read-stage command
- rd_addr  in  12  read-stage address
- sdram_cmd  out  5  command to the SDRAM pins
- sdram_addr  out  12  address to the SDRAM pins
- arb_err  out  1  one-cycle pulse on watchdog abort (only with ARBIT_WDT_EN)

Function
REQ-002 SHALL implement the FSM states IDLE, ARBIT, AREF, WRITE and READ.
REQ-003 SHALL leave IDLE for ARBIT on the first edge with flag_init=1. flag_init is sampled only in IDLE.
REQ-004 SHALL, in ARBIT, grant with fixed priority aref_req > wr_req > rd_req. The next state is AREF, WRITE or READ respectively. With no request the FSM stays in ARBIT.
REQ-005 SHALL decode aref_en, wr_en and rd_en from the registered state: each is 1 exactly while in AREF, WRITE or READ respectively. At most one is high in any cycle.
REQ-006 SHALL leave AREF, WRITE or READ for ARBIT on the edge where the matching ack is 1. Acks arriving in any other state are ignored.
REQ-007 SHALL drive wr_break = aref_req AND state==WRITE, and rd_break = aref_req AND state==READ, combinationally.
REQ-008 SHALL register the command/address mux with 1-cycle latency, selected by the current state:
- IDLE: init_cmd/init_addr
- AREF: aref_cmd/aref_addr
- WRITE: wr_cmd/wr_addr
- READ: rd_cmd/rd_addr
- ARBIT: NOP 5'b10111 and address 0
REQ-009 SHALL service aref_req, when it rises together with wr_req or rd_req in ARBIT, first. The write or read is granted on the ARBIT visit after aref_ack.
REQ-010 SHALL spend at least one cycle in ARBIT between any two grants, with NOP driven on the pins for that cycle.

Reset
REQ-011 SHALL, on RST=1 at an edge, force state=IDLE, sdram_cmd=5'b10111, sdram_addr=0 and arb_err=0. aref_en, wr_en and rd_en are therefore 0 from the next cycle.
REQ-012 SHALL take reset from any state, including mid-burst or mid-refresh, with no further command issued.

Configuration
REQ-013 SHALL compile a grant watchdog only when macro ARBIT_WDT_EN is defined.
- Defined: an 8-bit counter is cleared on every grant and increments in AREF, WRITE and READ. At a count of 255 without the matching ack, the FSM returns to ARBIT and arb_err pulses high for 1 cycle.
- Undefined: no counter is built, arb_err is tied to 0, and a grant lasts until its ack arrives.

Verification
REQ-014 Scenario: RST held 3 cycles, then flag_init=1 -> sdram_cmd=10111 during reset; state=ARBIT 1 edge after flag_init; pins show NOP.
REQ-015 Scenario: aref_req, wr_req and rd_req all rise in the same ARBIT cycle -> aref_en=1 next cycle. After aref_ack: one ARBIT cycle, then wr_en=1. After wr_ack: one ARBIT cycle, then rd_en=1.
REQ-016 Scenario: in WRITE, aref_req=1 -> wr_break=1 in the same cycle. wr_ack 4 cycles later -> ARBIT, then aref_en=1.
REQ-017 Scenario: in AREF, aref_cmd=10010 at cycle n -> sdram_cmd=10010 at cycle n+1. A rd_ack received in AREF is ignored and the state stays AREF.
REQ-018 Scenario: RST=1 mid-READ -> rd_en=0 and sdram_cmd=10111 next cycle; after RST falls, the FSM stays in IDLE until flag_init=1.
REQ-019 Scenario, with ARBIT_WDT_EN defined: grant WRITE, withhold wr_ack for 255 cycles -> arb_err pulse, wr_en=0, state ARBIT. Without the macro: wr_en stays 1 for 300 cycles and arb_err stays 0.
